// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment type, fixed patterns and the
// BCD decoder used by every display consumer.
package seg_pkg;

    // Active-low {g,f,e,d,c,b,a}
    typedef logic [6:0] seg_t;

    typedef enum logic {
        PH_VISIBLE = 1'b0,
        PH_HIDDEN  = 1'b1
    } blink_ph_e;

    localparam int   NUM_DIGITS = 4;
    localparam seg_t SEG_BLANK  = 7'b1111111;
    localparam seg_t SEG_DASH   = 7'b0111111;

    // Non-BCD codes show a dash so a corrupted digit is visible, not silent
    function automatic seg_t bcd_decode(input logic [3:0] bcd);
        seg_t s;
        case (bcd)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Pure combinational BCD to active-low seven-segment decoder.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = bcd_decode(bcd_i);

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed 4-digit common-anode display driver with anti-ghosting
// guard window, tear-free digit snapshot and adjust-mode pair blinking.
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2000,
    parameter int BLINK_DIV   = 50000000,
    parameter int DP_DIGIT    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    input  logic       blink_en,
    input  logic       blink_sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0]  GUARD_END  = SLOT_W'(GUARD);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [1:0]         DP_IDX     = 2'(DP_DIGIT);

    logic [SLOT_W-1:0]                 slot_q, slot_d;
    logic [1:0]                        idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]        snap_q, snap_d;
    logic                              first_q, first_d;
    logic [BLINK_W-1:0]                blink_cnt_q, blink_cnt_d;
    blink_ph_e                         phase_q, phase_d;
    logic [3:0]                        an_q, an_d;
    seg_t                              seg_q, seg_d;
    logic                              dp_q, dp_d;

    logic       slot_wrap;
    logic       scan_wrap;
    logic [3:0] cur_digit;
    seg_t       dec_seg;
    logic       in_guard;
    logic       in_sel_pair;
    logic       hide;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q      <= '0;
            idx_q       <= '0;
            snap_q      <= '0;
            first_q     <= 1'b1;
            blink_cnt_q <= '0;
            phase_q     <= PH_VISIBLE;
            an_q        <= 4'b1111;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            first_q     <= first_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    // Next-state logic
    always_comb begin
        slot_wrap = (slot_q == SLOT_LAST);
        scan_wrap = slot_wrap && (idx_q == 2'd3);

        slot_d  = slot_wrap ? '0 : slot_q + 1'b1;
        idx_d   = slot_wrap ? idx_q + 2'd1 : idx_q;
        first_d = 1'b0;

        // Digits only change between scans so one scan never mixes old and new
        snap_d = snap_q;
        if (scan_wrap || first_q) begin
            snap_d = {dig3, dig2, dig1, dig0};
        end

        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (!blink_en) begin
            blink_cnt_d = '0;
            phase_d     = PH_VISIBLE;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    assign cur_digit = snap_q[idx_q];

    bcd_to_seg u_dec (
        .bcd_i (cur_digit),
        .seg_o (dec_seg)
    );

    // Output logic; blink_en is used live so dropping it unhides on the next cycle
    always_comb begin
        in_guard    = (slot_q < GUARD_END);
        in_sel_pair = blink_sel ? (idx_q[1] == 1'b0) : (idx_q[1] == 1'b1);
        hide        = blink_en && (phase_q == PH_HIDDEN) && in_sel_pair;

        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (!in_guard && !hide) begin
            an_d[idx_q] = 1'b0;
            seg_d       = dec_seg;
            dp_d        = (idx_q != DP_IDX);
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench: the driver pushes one expected entry per lit digit window,
// the monitor pops one each time a digit lights and checks value and duration.
module tb_seg_display_scanner;

    localparam int RD  = 8;
    localparam int GD  = 2;
    localparam int BD  = 40;
    localparam int DPD = 2;
    localparam int WIN = RD - GD;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic       blink_en, blink_sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int   checks   = 0;
    int   failures = 0;
    int   cyc;
    exp_t q[$];

    always #5 clk = ~clk;

    seg_display_scanner #(
        .REFRESH_DIV (RD),
        .GUARD       (GD),
        .BLINK_DIV   (BD),
        .DP_DIGIT    (DPD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dig0      (dig0),
        .dig1      (dig1),
        .dig2      (dig2),
        .dig3      (dig3),
        .blink_en  (blink_en),
        .blink_sel (blink_sel),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    // Rising edges since the last reset release
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_slot(input int i, input logic [3:0] d, input int len);
        exp_t e;
        e.an    = 4'b1111;
        e.an[i] = 1'b0;
        e.seg   = seg_of(d);
        e.dp    = (i == DPD) ? 1'b0 : 1'b1;
        e.len   = len;
        q.push_back(e);
    endtask

    // hide[i]=1 means digit i stays dark for the whole scan
    task automatic exp_scan(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                            input logic [3:0] d0, input logic [3:0] hide);
        logic [3:0] dv [4];
        dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
        for (int i = 0; i < 4; i++)
            if (!hide[i]) exp_slot(i, dv[i], WIN);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic set_dig(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                           input logic [3:0] d0);
        dig3 = d3; dig2 = d2; dig1 = d1; dig0 = d0;
    endtask

    // Monitor: one scoreboard pop per lit window, plus window length check
    initial begin
        logic       in_run;
        logic [11:0] run_val, cur;
        int         run_len, run_exp_len;
        exp_t       e;
        in_run = 1'b0; run_val = '0; run_len = 0; run_exp_len = 0;
        forever begin
            @(negedge clk);
            cur = {an, seg, dp};
            if ($countones(~an) > 1) begin
                failures++;
                $display("FAIL an_onehot: an=%b has more than one low bit", an);
            end
            if (in_run && cur != run_val) begin
                check("window_len", run_len, run_exp_len);
                in_run = 1'b0;
            end else if (in_run) begin
                run_len++;
            end
            if (!in_run && an != 4'b1111) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_digit: an=%b seg=%b dp=%b, nothing expected", an, seg, dp);
                    run_exp_len = 0;
                end else begin
                    e = q.pop_front();
                    check("an", 32'(an), 32'(e.an));
                    check("seg", 32'(seg), 32'(e.seg));
                    check("dp", 32'(dp), 32'(e.dp));
                    run_exp_len = e.len;
                end
                in_run  = 1'b1;
                run_len = 1;
                run_val = cur;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        set_dig(4'd1, 4'd2, 4'd3, 4'd4);
        blink_en  = 1'b0;
        blink_sel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        rst = 1'b0;

        exp_scan(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
        wait_cyc(2);
        check("guard_an", 32'(an), 32'hF);
        wait_cyc(3);
        check("first_an", 32'(an), 32'b1110);
        check("first_seg", 32'(seg), 32'(seg_of(4'd4)));

        // Mid-scan change: current scan unchanged, next scan shows new values
        wait_cyc(32);  exp_scan(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
        wait_cyc(40);  dig0 = 4'd5; dig2 = 4'd7;
        wait_cyc(64);  exp_scan(4'd1, 4'd7, 4'd3, 4'd5, 4'b0000);
        wait_cyc(70);  set_dig(4'd6, 4'd8, 4'd9, 4'hC);
        wait_cyc(96);  exp_scan(4'd6, 4'd8, 4'd9, 4'hC, 4'b0000);
        wait_cyc(100); set_dig(4'd0, 4'd1, 4'hA, 4'd7);
        wait_cyc(128); exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b0000);

        // Seconds pair blinks; rise timed so the hidden phase covers whole slots
        wait_cyc(152); blink_en = 1'b1; blink_sel = 1'b1;
        wait_cyc(160); exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b0000);
        wait_cyc(192); exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b0011);
        wait_cyc(224); exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b0001);
        wait_cyc(256); exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b0000);
        // Drop mid-window while hidden: digit 0 lights for the last 3 cycles
        wait_cyc(288);
        exp_slot(0, 4'd7, 3);
        exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b0001);
        wait_cyc(293); blink_en = 1'b0;

        // Re-raise: phase restarts visible
        wait_cyc(320); exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b0000);
        wait_cyc(344); blink_en = 1'b1;
        wait_cyc(352); exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b0000);
        wait_cyc(384); exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b0011);
        wait_cyc(416); exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b0001);
        wait_cyc(440); blink_en = 1'b0;
        wait_cyc(448); exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b0000);

        // Minutes pair blinks
        wait_cyc(480); exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b0000);
        wait_cyc(488); blink_en = 1'b1; blink_sel = 1'b0;
        wait_cyc(512); exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b1100);
        wait_cyc(544); exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b0100);
        wait_cyc(576); exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b0000);
        wait_cyc(590); blink_en = 1'b0;

        // Reset during digit 2's active window
        wait_cyc(608);
        exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b1100);
        exp_slot(2, 4'd1, 2);
        wait_cyc(628);
        check("pre_rst_an", 32'(an), 32'b1011);
        check("pre_rst_dp", 32'(dp), 32'h0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_an", 32'(an), 32'hF);
        check("async_rst_seg", 32'(seg), 32'h7F);
        check("async_rst_dp", 32'(dp), 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b0000);
        wait_cyc(2);
        check("rerst_guard_an", 32'(an), 32'hF);
        wait_cyc(3);
        check("rerst_first_an", 32'(an), 32'b1110);
        check("rerst_first_seg", 32'(seg), 32'(seg_of(4'd7)));
        wait_cyc(32); exp_scan(4'd0, 4'd1, 4'hA, 4'd7, 4'b0000);
        wait_cyc(66);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Consumer of the stopwatch counter's four BCD digits.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display with active-low anodes and segments.
- Blinks the digit pair being adjusted while adjust mode is active.
- Sits between the counter and the board pins; it is the only block that drives an/seg/dp.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); must be >= GUARD+2
- GUARD, 2000, cycles at the start of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV
- BLINK_DIV, 50000000, clk cycles per blink half-period (visible/hidden phase length)
- DP_DIGIT, 2, digit position whose decimal point is lit (mm.ss separator)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- dig0  in  4  BCD, seconds units (rightmost digit)
- dig1  in  4  BCD, seconds tens
- dig2  in  4  BCD, minutes units
- dig3  in  4  BCD, minutes tens (leftmost digit)
- blink_en  in  1  adjust mode active; selected pair blinks
- blink_sel  in  1  1 = blink dig1:dig0 (seconds), 0 = blink dig3:dig2 (minutes)
- an  out  4  anode enables, active-low; an[i] drives digit i
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

Behaviour:
- Reset (async, asserted):
  - an=4'b1111, seg=7'b1111111, dp=1
  - slot counter=0, scan index=0, blink counter=0, blink phase=visible, snapshot regs=0
- Slot counter counts 0..REFRESH_DIV-1, then wraps to 0 and advances the scan index 0->1->2->3->0.
- Snapshot:
  - All four dig inputs are captured into snapshot regs on the cycle the index wraps 3->0, and on the first cycle after reset release.
  - The display never shows a mix of old and new digits within one scan (no tearing).
  - Worst-case display latency of an input change: 4*REFRESH_DIV+1 cycles.
- Outputs are registered; an/seg/dp reflect the counter/index state of the previous cycle (1-cycle lag).
- Guard window, slot counter < GUARD:
  - an=1111, seg=1111111, dp=1.
- Active window, slot counter >= GUARD:
  - an has only bit [index] low.
  - seg = decode(snapshot[index]).
  - dp=0 iff index==DP_DIGIT.
- Decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10-15 = dash 0111111
- Blink:
  - The blink counter runs only while blink_en=1. It counts 0..BLINK_DIV-1, and at wrap the phase toggles.
  - When blink_en=0, the counter is held at 0 and the phase is forced to visible. The first BLINK_DIV cycles after blink_en rises are therefore visible.
  - In the hidden phase, digits of the selected pair have an bit forced high (seg=1111111, dp=1). The other pair is unaffected.
  - A blink_sel change takes effect from the next cycle with no phase reset.
- Simultaneous events:
  - Slot wrap and blink toggle in the same cycle are both applied.
  - Index wrap coinciding with reset release is ignored; reset wins.
- Reset mid-scan: outputs blank immediately (async); the scan restarts at index 0, guard window first.
- Invariant: at most one an bit is low in any cycle.

Decomposition:
- Shared package seg_pkg:
  - 7-bit segment typedef
  - SEG_BLANK and SEG_DASH constants
  - decode function for BCD -> active-low segments
- One natural sub-module: bcd_to_seg, a pure combinational decoder.
  - Reusable by any other display consumer.
  - Instantiated once, on the muxed snapshot digit.

Test Plan (sim params REFRESH_DIV=8, GUARD=2, BLINK_DIV=40, DP_DIGIT=2):
- Reset, then dig3..0=1,2,3,4, blink_en=0 -> an sequence per slot is 1111 x2 followed by 1110/1101/1011/0111 x6. seg is 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1). dp=0 only while an=1011.
- Change dig0 from 4 to 5 at index 1 -> digit 0 still shows 4 on the next slot 0 before the snapshot? No: the snapshot is taken at wrap 3->0, so digit 0 shows 5 only from the following scan. The remaining slots of the current scan are unchanged.
- dig0=4'hC -> seg=0111111 during digit 0's active window.
- blink_en=1, blink_sel=1 -> digits 0/1 are visible for 40 cycles, then an[1:0] are held high for 40 cycles while digits 2/3 keep scanning normally. Then visible again.
- blink_en dropped during the hidden phase -> all digits are visible the next cycle; raising it again gives 40 visible cycles first.
- Assert rst during the digit 2 active window -> an=1111, seg=1111111, dp=1 in the same cycle. After release, index 0 resumes with the guard first. An assertion checks that no more than one an bit is ever low.
